// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared definitions for kernel go/done control blocks: state encoding and
// handshake polarity of the valid/holdoff and valid/stop channels.
package sda_kernel_ctrl_pkg;

    localparam int unsigned KernelCtrlStateWidth = 2;

    typedef enum logic [KernelCtrlStateWidth-1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_RUNNING  = 2'd2,
        ST_COMPLETE = 2'd3
    } kernel_ctrl_state_e;

    // Back-pressure (holdoff/stop) is active-high; HsPass lets a valid through.
    localparam logic HsHold = 1'b1;
    localparam logic HsPass = 1'b0;

    function automatic logic hs_xfer(input logic valid, input logic hold);
        return valid & (hold == HsPass);
    endfunction

endpackage

// File: rtl/sda_rr_priority_select.sv
// Round-robin pick: rotate requests by the pointer, take the lowest set bit,
// and rotate the resulting offset back into a requester index.
module sda_rr_priority_select #(
    parameter int unsigned NumRequesters = 4,
    parameter int unsigned IdWidth       = 2
) (
    input  logic [NumRequesters-1:0] req_vec,
    input  logic [IdWidth-1:0]       ptr,
    output logic [IdWidth-1:0]       grant_id,
    output logic                     grant_valid
);

    localparam int unsigned N    = NumRequesters;
    localparam int unsigned SumW = IdWidth + 1;

    logic [2*N-1:0]     req_dbl;
    logic [N-1:0]       rotated;
    logic [IdWidth-1:0] offset;
    logic [SumW-1:0]    sum;

    always_comb begin
        req_dbl = {req_vec, req_vec};
        rotated = N'(req_dbl >> ptr);
        offset  = '0;
        // Descending scan so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IdWidth'(i);
            end
        end
        grant_valid = |rotated;
        sum = SumW'(ptr) + SumW'(offset);
        if (sum >= SumW'(N)) begin
            sum = sum - SumW'(N);
        end
        grant_id = IdWidth'(sum);
    end

endmodule

// File: rtl/sda_kernel_go_arbiter.sv
// Round-robin arbiter sharing one kernel reset handler go/done channel among
// several requesters, with a run-time watchdog that requests a system reset.
module sda_kernel_go_arbiter
    import sda_kernel_ctrl_pkg::*;
#(
    parameter int unsigned NumRequesters     = 4,
    parameter int unsigned IdWidth           = 2,
    parameter int unsigned WatchdogCountSize = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NumRequesters-1:0]     reqGoValid,
    output logic [NumRequesters-1:0]     reqGoHoldoff,
    output logic [NumRequesters-1:0]     reqDoneValid,
    input  logic [NumRequesters-1:0]     reqDoneStop,
    output logic                         hdlGoValid,
    input  logic                         hdlGoHoldoff,
    input  logic                         hdlDoneValid,
    output logic                         hdlDoneStop,
    input  logic [WatchdogCountSize-1:0] watchdogLimit,
    output logic                         sysRstReq,
    output logic [NumRequesters-1:0]     timeoutFlags,
    output logic [IdWidth-1:0]           activeId,
    output logic                         busy
);

    localparam int unsigned N   = NumRequesters;
    localparam int unsigned WdW = WatchdogCountSize;

    kernel_ctrl_state_e state_q, state_d;
    logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0] active_id_q, active_id_d;
    logic               hdl_go_valid_q, hdl_go_valid_d;
    logic               hdl_done_stop_q, hdl_done_stop_d;
    logic               sys_rst_req_q, sys_rst_req_d;
    logic               busy_q, busy_d;
    logic [N-1:0]       req_done_valid_q, req_done_valid_d;
    logic [N-1:0]       timeout_flags_q, timeout_flags_d;
    logic [WdW-1:0]     wd_cnt_q, wd_cnt_d;

    logic [IdWidth-1:0] grant_id;
    logic               grant_valid;
    logic               hdl_go_xfer_c;
    logic               hdl_done_xfer_c;
    logic               req_done_xfer_c;
    logic               wd_expired_c;
    logic [IdWidth-1:0] next_ptr_c;

    sda_rr_priority_select #(
        .NumRequesters (N),
        .IdWidth       (IdWidth)
    ) u_rr_select (
        .req_vec     (reqGoValid),
        .ptr         (rr_ptr_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Handshake and watchdog qualifiers.
    always_comb begin
        hdl_go_xfer_c   = hs_xfer(hdl_go_valid_q, hdlGoHoldoff);
        hdl_done_xfer_c = hs_xfer(hdlDoneValid, hdl_done_stop_q);
        req_done_xfer_c = hs_xfer(req_done_valid_q[active_id_q], reqDoneStop[active_id_q]);
        wd_expired_c    = (watchdogLimit != '0) && (wd_cnt_q == watchdogLimit - WdW'(1));
        next_ptr_c      = (32'(active_id_q) == N - 1) ? '0 : active_id_q + IdWidth'(1);
    end

    // Only the granted requester sees the handler's holdoff, and only in Issue.
    always_comb begin
        reqGoHoldoff = {N{HsHold}};
        if (state_q == ST_ISSUE) begin
            reqGoHoldoff[active_id_q] = hdlGoHoldoff;
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        active_id_d      = active_id_q;
        hdl_go_valid_d   = hdl_go_valid_q;
        hdl_done_stop_d  = hdl_done_stop_q;
        req_done_valid_d = req_done_valid_q;
        timeout_flags_d  = timeout_flags_q;
        wd_cnt_d         = wd_cnt_q;
        sys_rst_req_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    active_id_d               = grant_id;
                    timeout_flags_d[grant_id] = 1'b0;
                    hdl_go_valid_d            = 1'b1;
                    state_d                   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hdl_go_xfer_c) begin
                    hdl_go_valid_d  = 1'b0;
                    hdl_done_stop_d = HsPass;
                    wd_cnt_d        = '0;
                    state_d         = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + WdW'(1);
                end
                // A done arriving on the expiry cycle takes priority over abort.
                if (hdl_done_xfer_c) begin
                    hdl_done_stop_d               = HsHold;
                    req_done_valid_d[active_id_q] = 1'b1;
                    state_d                       = ST_COMPLETE;
                end else if (wd_expired_c) begin
                    sys_rst_req_d                 = 1'b1;
                    timeout_flags_d[active_id_q]  = 1'b1;
                    hdl_done_stop_d               = HsHold;
                    req_done_valid_d[active_id_q] = 1'b1;
                    state_d                       = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                if (req_done_xfer_c) begin
                    req_done_valid_d = '0;
                    rr_ptr_d         = next_ptr_c;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= '0;
            active_id_q      <= '0;
            hdl_go_valid_q   <= 1'b0;
            hdl_done_stop_q  <= HsHold;
            req_done_valid_q <= '0;
            timeout_flags_q  <= '0;
            wd_cnt_q         <= '0;
            sys_rst_req_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            active_id_q      <= active_id_d;
            hdl_go_valid_q   <= hdl_go_valid_d;
            hdl_done_stop_q  <= hdl_done_stop_d;
            req_done_valid_q <= req_done_valid_d;
            timeout_flags_q  <= timeout_flags_d;
            wd_cnt_q         <= wd_cnt_d;
            sys_rst_req_q    <= sys_rst_req_d;
            busy_q           <= busy_d;
        end
    end

    assign hdlGoValid   = hdl_go_valid_q;
    assign hdlDoneStop  = hdl_done_stop_q;
    assign reqDoneValid = req_done_valid_q;
    assign sysRstReq    = sys_rst_req_q;
    assign timeoutFlags = timeout_flags_q;
    assign activeId     = active_id_q;
    assign busy         = busy_q;

endmodule
